// File: rtl/sccb_dual_cam_scheduler.sv
// Round-robin arbiter that shares one SCCB sender between the left and right OV7670
// register ROMs, executes ROM delay tokens locally and flags per-camera send timeouts.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// ARB    | pick the next eligible camera, latch its command, steer the bus
// ISSUE  | snd_send held high until snd_taken or timeout
// ADV    | one-cycle advance pulse to the granted ROM
// GUARD  | bus held on the granted camera while the transfer finishes
// DELAY  | ROM delay token being executed, nothing sent
module sccb_dual_cam_scheduler #(
   parameter logic [7:0]  CAM_ID0        = 8'h42,
   parameter logic [7:0]  CAM_ID1        = 8'h42,
   parameter logic [15:0] DELAY_TOKEN    = 16'hFFF0,
   parameter int          DELAY_CYCLES   = 250000,
   parameter int          GUARD_CYCLES   = 2048,
   parameter int          TIMEOUT_CYCLES = 65536,
   parameter int          CNT_W          = 24
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] req_cmd0,
   input  logic        req_fin0,
   output logic        adv0,
   input  logic [15:0] req_cmd1,
   input  logic        req_fin1,
   output logic        adv1,
   output logic        snd_send,
   output logic [7:0]  snd_id,
   output logic [7:0]  snd_reg,
   output logic [7:0]  snd_value,
   input  logic        snd_taken,
   output logic        bus_sel,
   output logic [1:0]  cfg_done,
   output logic        all_done,
   output logic [1:0]  err
);

   localparam logic [CNT_W-1:0] DLY_LD = CNT_W'(DELAY_CYCLES - 1);
   localparam logic [CNT_W-1:0] GRD_LD = CNT_W'(GUARD_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LD = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [2:0] {
      ST_ARB,
      ST_ISSUE,
      ST_ADV,
      ST_GUARD,
      ST_DELAY
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             rr;
   logic             grant;
   logic             to_guard;

   logic             elig0;
   logic             elig1;
   logic             arb_grant;
   logic [15:0]      arb_cmd;
   logic             cnt_zero;

   assign elig0     = ~req_fin0;
   assign elig1     = ~req_fin1;
   assign arb_grant = (elig0 & elig1) ? rr : ~elig0;
   assign arb_cmd   = arb_grant ? req_cmd1 : req_cmd0;
   assign cnt_zero  = (cnt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_ARB;
         cnt       <= '0;
         rr        <= 1'b0;
         grant     <= 1'b0;
         to_guard  <= 1'b0;
         snd_send  <= 1'b0;
         snd_id    <= 8'h00;
         snd_reg   <= 8'h00;
         snd_value <= 8'h00;
         adv0      <= 1'b0;
         adv1      <= 1'b0;
         bus_sel   <= 1'b0;
         cfg_done  <= 2'b00;
         all_done  <= 1'b0;
         err       <= 2'b00;
      end else begin
         cfg_done <= {req_fin1, req_fin0};
         all_done <= req_fin0 & req_fin1;
         adv0     <= 1'b0;
         adv1     <= 1'b0;

         case (state)
            ST_ARB: begin
               if (elig0 | elig1) begin
                  grant   <= arb_grant;
                  bus_sel <= arb_grant;
                  if (arb_cmd == DELAY_TOKEN) begin
                     cnt   <= DLY_LD;
                     state <= ST_DELAY;
                  end else begin
                     snd_id    <= arb_grant ? CAM_ID1 : CAM_ID0;
                     snd_reg   <= arb_cmd[15:8];
                     snd_value <= arb_cmd[7:0];
                     snd_send  <= 1'b1;
                     cnt       <= TMO_LD;
                     state     <= ST_ISSUE;
                  end
               end
            end

            // taken wins over a timeout landing on the same cycle
            ST_ISSUE: begin
               if (snd_taken) begin
                  snd_send <= 1'b0;
                  to_guard <= 1'b1;
                  adv0     <= ~grant;
                  adv1     <= grant;
                  state    <= ST_ADV;
               end else if (cnt_zero) begin
                  err[grant] <= 1'b1;
                  snd_send   <= 1'b0;
                  to_guard   <= 1'b0;
                  adv0       <= ~grant;
                  adv1       <= grant;
                  state      <= ST_ADV;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end

            ST_ADV: begin
               if (to_guard) begin
                  cnt   <= GRD_LD;
                  state <= ST_GUARD;
               end else begin
                  state <= ST_ARB;
               end
            end

            ST_GUARD: begin
               if (cnt_zero) begin
                  rr    <= ~grant;
                  state <= ST_ARB;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end

            ST_DELAY: begin
               if (cnt_zero) begin
                  rr       <= ~grant;
                  to_guard <= 1'b0;
                  adv0     <= ~grant;
                  adv1     <= grant;
                  state    <= ST_ADV;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end

            default: state <= ST_ARB;
         endcase
      end
   end

endmodule

// File: tb/tb_sccb_dual_cam_scheduler.sv
// Bench for sccb_dual_cam_scheduler: two ROM fixtures, a sender stub and a
// transaction-level scheduling model; directed steps followed by randomized rounds.
module tb_sccb_dual_cam_scheduler;

   localparam int          GRD = 8;
   localparam int          DLY = 20;
   localparam int          TMO = 16;
   localparam logic [15:0] TOK = 16'hFFF0;
   localparam logic [7:0]  ID0 = 8'h42;
   localparam logic [7:0]  ID1 = 8'h43;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] req_cmd0, req_cmd1;
   logic        req_fin0, req_fin1;
   logic        adv0, adv1;
   logic        snd_send;
   logic [7:0]  snd_id, snd_reg, snd_value;
   logic        snd_taken = 1'b0;
   logic        bus_sel;
   logic [1:0]  cfg_done;
   logic        all_done;
   logic [1:0]  err;

   logic [15:0] rom [2][16];
   int          fidx [2];
   int          lenv [2];
   int          em_idx [2];
   logic        rr_m = 1'b0;
   logic [1:0]  err_m = 2'b00;
   logic [1:0]  adv_q = 2'b00;
   int          n_tests = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   assign req_cmd0 = rom[0][fidx[0][3:0]];
   assign req_cmd1 = rom[1][fidx[1][3:0]];
   assign req_fin0 = (fidx[0] >= lenv[0]);
   assign req_fin1 = (fidx[1] >= lenv[1]);

   sccb_dual_cam_scheduler #(
      .CAM_ID0(ID0), .CAM_ID1(ID1), .DELAY_TOKEN(TOK), .DELAY_CYCLES(DLY),
      .GUARD_CYCLES(GRD), .TIMEOUT_CYCLES(TMO), .CNT_W(24)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_cmd0(req_cmd0), .req_fin0(req_fin0), .adv0(adv0),
      .req_cmd1(req_cmd1), .req_fin1(req_fin1), .adv1(adv1),
      .snd_send(snd_send), .snd_id(snd_id), .snd_reg(snd_reg), .snd_value(snd_value),
      .snd_taken(snd_taken), .bus_sel(bus_sel),
      .cfg_done(cfg_done), .all_done(all_done), .err(err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ROM fixture advances on the edge that ends the adv pulse
   task automatic step();
      @(posedge clk);
      #1;
      if (adv_q[0]) fidx[0]++;
      if (adv_q[1]) fidx[1]++;
      adv_q = {adv1, adv0};
   endtask

   // One scheduled command, starting from a cycle where the scheduler sits in ARB.
   // lat = ISSUE cycles before snd_taken; lat >= TMO means the sender never takes it.
   task automatic txn(input int lat);
      logic        e0, e1, g;
      logic [15:0] cmd;
      bit          tmo;
      int          n;
      tmo = 1'b0;
      e0 = (em_idx[0] < lenv[0]);
      e1 = (em_idx[1] < lenv[1]);
      if (!e0 && !e1) begin
         step();
         chk("idle_send", snd_send, 1'b0);
         return;
      end
      g   = (e0 && e1) ? rr_m : !e0;
      cmd = rom[g][em_idx[g]];
      step();
      chk("grant_bus_sel", bus_sel, g);
      chk("grant_cfg_done", cfg_done, {!e1, !e0});
      chk("grant_all_done", all_done, 1'b0);
      if (cmd == TOK) begin
         for (int i = 0; i < DLY; i++) begin
            chk("delay_send", snd_send, 1'b0);
            chk("delay_adv", {adv1, adv0}, 2'b00);
            step();
         end
      end else begin
         chk("issue_send_rise", snd_send, 1'b1);
         chk("issue_id", snd_id, g ? ID1 : ID0);
         chk("issue_reg", snd_reg, cmd[15:8]);
         chk("issue_value", snd_value, cmd[7:0]);
         tmo = (lat >= TMO);
         n   = tmo ? TMO : lat;
         for (int i = 0; i < n; i++) begin
            chk("issue_hold_send", snd_send, 1'b1);
            chk("issue_hold_reg", {snd_id, snd_reg, snd_value}, {(g ? ID1 : ID0), cmd});
            chk("issue_hold_bus", bus_sel, g);
            chk("issue_adv", {adv1, adv0}, 2'b00);
            step();
         end
         if (!tmo) begin
            snd_taken = 1'b1;
            step();
            snd_taken = 1'b0;
         end else begin
            err_m[g] = 1'b1;
         end
         chk("adv_send_low", snd_send, 1'b0);
         chk("adv_err", err, err_m);
      end
      chk("adv_pulse", {adv1, adv0}, g ? 2'b10 : 2'b01);
      chk("adv_bus_sel", bus_sel, g);
      em_idx[g]++;
      if (cmd != TOK && !tmo) begin
         for (int i = 0; i < GRD; i++) begin
            snd_taken = 1'($urandom_range(0, 1));
            step();
            chk("guard_send", snd_send, 1'b0);
            chk("guard_adv", {adv1, adv0}, 2'b00);
            chk("guard_bus_sel", bus_sel, g);
         end
         snd_taken = 1'b0;
      end
      step();
      chk("arb_adv_low", {adv1, adv0}, 2'b00);
      chk("arb_send_low", snd_send, 1'b0);
      if (cmd == TOK || !tmo) rr_m = ~g;
   endtask

   task automatic load_random_roms();
      for (int c = 0; c < 2; c++) begin
         lenv[c]   = $urandom_range(3, 8);
         fidx[c]   = 0;
         em_idx[c] = 0;
         for (int k = 0; k < 16; k++)
            rom[c][k] = ($urandom_range(0, 7) == 0) ? TOK : 16'($urandom_range(0, 16'hFFEF));
      end
   endtask

   initial begin
      int lat;
      int r;
      rom[0] = '{16'h1280, 16'h0A01, 16'h0B02, 16'h0C03, TOK, 16'h3A04, 16'h3B05, 16'h3C06,
                 16'h4001, 16'h4102, 16'h4203, 16'h4304, 16'h4405, 16'h4506, 16'h4607, 16'h4708};
      rom[1] = '{16'h1180, 16'h1501, 16'h1602, 16'h1703, 16'h1804, 16'h1905, 16'h1A06, 16'h1B07,
                 16'h5001, 16'h5102, 16'h5203, 16'h5304, 16'h5405, 16'h5506, 16'h5607, 16'h5708};
      fidx   = '{0, 0};
      em_idx = '{0, 0};
      lenv   = '{16, 16};

      // reset with both ROMs unfinished
      repeat (5) step();
      rst_n = 1'b1;
      chk("rst_send", snd_send, 1'b0);
      chk("rst_bus_sel", bus_sel, 1'b0);
      chk("rst_adv", {adv1, adv0}, 2'b00);
      chk("rst_cfg_done", cfg_done, 2'b00);
      chk("rst_err", err, 2'b00);
      chk("rst_snd_fields", {snd_id, snd_reg, snd_value}, 24'h0);

      // round-robin 0 then 1
      txn(4);
      txn(2);

      // camera 1 finished: everything goes to camera 0
      lenv[1] = em_idx[1];
      txn(1);
      txn(1);
      txn(1);
      chk("one_done_cfg", cfg_done, 2'b10);

      // camera 1 reopened; camera 0 then hits its delay token
      lenv[1] = 16;
      txn(0);
      txn(0);
      txn(3);

      // timeout on camera 0, then a take on the last timeout cycle
      txn(100);
      chk("timeout_err", err, 2'b01);
      txn(TMO - 1);
      chk("boundary_err", err, 2'b01);

      // all done, then camera 0 resends
      lenv[0] = em_idx[0];
      lenv[1] = em_idx[1];
      step();
      step();
      chk("all_done_high", all_done, 1'b1);
      chk("all_cfg_done", cfg_done, 2'b11);
      chk("all_idle_send", snd_send, 1'b0);
      lenv[0] = em_idx[0] + 1;
      step();
      chk("resend_all_done", all_done, 1'b0);
      chk("resend_cfg_done", cfg_done, 2'b10);
      chk("resend_send", snd_send, 1'b1);
      chk("resend_bus_sel", bus_sel, 1'b0);
      chk("resend_reg", snd_reg, rom[0][em_idx[0]][15:8]);
      step();

      // reset mid-ISSUE aborts at once with no advance
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_send", snd_send, 1'b0);
      chk("midrst_adv", {adv1, adv0}, 2'b00);
      chk("midrst_err", err, 2'b00);
      chk("midrst_bus_sel", bus_sel, 1'b0);
      rr_m  = 1'b0;
      err_m = 2'b00;

      // randomized rounds against the model
      for (int rnd = 0; rnd < 3; rnd++) begin
         rst_n = 1'b0;
         load_random_roms();
         rr_m  = 1'b0;
         err_m = 2'b00;
         repeat (3) begin
            step();
            chk("rst_hold_adv", {adv1, adv0}, 2'b00);
         end
         rst_n = 1'b1;
         for (int t = 0; t < 40; t++) begin
            if (em_idx[0] >= lenv[0] && em_idx[1] >= lenv[1]) break;
            r   = $urandom_range(0, 9);
            lat = (r == 0) ? 40 : (r == 1) ? TMO - 1 : $urandom_range(0, 5);
            txn(lat);
         end
         step();
         chk("rnd_cfg_done", cfg_done, 2'b11);
         chk("rnd_all_done", all_done, 1'b1);
         chk("rnd_err", err, err_m);
         chk("rnd_rom0_pos", fidx[0], em_idx[0]);
         chk("rnd_rom1_pos", fidx[1], em_idx[1]);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
